// File: rtl/packet_sram_loader_pkg.sv
// Shared types and sizing helpers for the packet SRAM loader.
// Provides the loader state encoding and default widths.
package pkt_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } loader_state_t;

   localparam int DEF_PACKET_W = 64;
   localparam int DEF_IN_W     = 16;
   localparam int DEF_ADDR_W   = 10;
   localparam int DEF_DEPTH    = 1024;

   // Host words that make up one packet.
   function automatic int words_per_packet(input int packet_w, input int in_w);
      return packet_w / in_w;
   endfunction

   // Beat counter width; one spare code so the counter can sit at WPP.
   function automatic int beat_width(input int wpp);
      return $clog2(wpp + 1);
   endfunction

endpackage

// File: rtl/packet_sram_loader_assembler.sv
// Packs host words into one packet-wide register, LSB slot first.
// Zero-pads the upper slots when the stream ends mid-packet.
module pkt_assembler
   import pkt_loader_pkg::*;
#(
   parameter int PACKET_W = DEF_PACKET_W,
   parameter int IN_W     = DEF_IN_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                accept,
   input  logic [IN_W-1:0]     in_data,
   input  logic                in_last,
   output logic [PACKET_W-1:0] data,
   output logic                pkt_end,
   output logic                last_flag
);

   localparam int WPP    = words_per_packet(PACKET_W, IN_W);
   localparam int BEAT_W = beat_width(WPP);

   logic [BEAT_W-1:0] beat_d, beat_q;
   logic              last_flag_d, last_flag_q;

   // High in the cycle where the accepted word completes the packet.
   assign pkt_end   = accept && ((beat_q == BEAT_W'(WPP - 1)) || in_last);
   assign last_flag = last_flag_q;

   always_comb begin
      beat_d      = beat_q;
      last_flag_d = last_flag_q;
      if (clear) begin
         beat_d      = '0;
         last_flag_d = 1'b0;
      end else if (accept) begin
         beat_d = beat_q + BEAT_W'(1);
         if (in_last) begin
            last_flag_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_q      <= '0;
         last_flag_q <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         last_flag_q <= last_flag_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WPP; gi++) begin : g_slot
         logic [IN_W-1:0] slot_d, slot_q;

         always_comb begin
            slot_d = slot_q;
            if (clear) begin
               slot_d = '0;
            end else if (accept) begin
               if (beat_q == BEAT_W'(gi)) begin
                  slot_d = in_data;
               end else if (in_last && (int'(beat_q) < gi)) begin
                  slot_d = '0;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               slot_q <= '0;
            end else begin
               slot_q <= slot_d;
            end
         end

         assign data[gi*IN_W +: IN_W] = slot_q;
      end
   endgenerate

endmodule

// File: rtl/packet_sram_loader.sv
// Write-side packet SRAM loader: assembles host words into packets and writes
// them to consecutive addresses from 0. Optional parity check: PKT_LOADER_PARITY_EN.
module packet_sram_loader
   import pkt_loader_pkg::*;
#(
   parameter int PACKET_W = DEF_PACKET_W,
   parameter int IN_W     = DEF_IN_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DEPTH    = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_start,
   input  logic                in_valid,
   input  logic [IN_W-1:0]     in_data,
   input  logic                in_last,
   output logic                in_ready,
   input  logic                sram_busy,
   output logic                sram_wen,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [PACKET_W-1:0] sram_wdata,
   output logic                load_busy,
   output logic                load_done,
   output logic [ADDR_W:0]     pkt_count,
`ifdef PKT_LOADER_PARITY_EN
   input  logic                in_par,
   output logic                parity_err,
`endif
   output logic                overflow_err
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   loader_state_t     state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [ADDR_W:0]   pkt_count_d, pkt_count_q;
   logic              overflow_d, overflow_q;

   logic                accept;
   logic                at_depth;
   logic                asm_clear;
   logic                asm_pkt_end;
   logic                asm_last;
   logic [PACKET_W-1:0] asm_data;

   assign in_ready = (state_q == COLLECT);
   assign accept   = in_valid && in_ready;
   assign at_depth = (pkt_count_q == DEPTH_CNT);

   // Write strobe depends only on state, arbitration and the full check, so the
   // read side can grab the port in the same cycle without a registered lag.
   assign sram_wen     = (state_q == WRITE) && !sram_busy && !at_depth;
   assign sram_addr    = addr_q;
   assign sram_wdata   = asm_data;
   assign load_busy    = (state_q != IDLE);
   assign load_done    = (state_q == DONE);
   assign pkt_count    = pkt_count_q;
   assign overflow_err = overflow_q;

   pkt_assembler #(
      .PACKET_W (PACKET_W),
      .IN_W     (IN_W)
   ) u_assembler (
      .clk       (clk),
      .reset     (reset),
      .clear     (asm_clear),
      .accept    (accept),
      .in_data   (in_data),
      .in_last   (in_last),
      .data      (asm_data),
      .pkt_end   (asm_pkt_end),
      .last_flag (asm_last)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pkt_count_d = pkt_count_q;
      overflow_d  = overflow_q;
      asm_clear   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_start) begin
               addr_d      = '0;
               pkt_count_d = '0;
               overflow_d  = 1'b0;
               asm_clear   = 1'b1;
               state_d     = COLLECT;
            end
         end
         COLLECT: begin
            if (asm_pkt_end) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            // The full check precedes the write so addr never runs past DEPTH-1.
            if (at_depth) begin
               overflow_d = 1'b1;
               state_d    = DONE;
            end else if (!sram_busy) begin
               addr_d      = addr_q + ADDR_W'(1);
               pkt_count_d = pkt_count_q + (ADDR_W + 1)'(1);
               asm_clear   = 1'b1;
               state_d     = asm_last ? DONE : COLLECT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         pkt_count_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pkt_count_q <= pkt_count_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef PKT_LOADER_PARITY_EN
   logic parity_d, parity_q;

   assign parity_err = parity_q;

   always_comb begin
      parity_d = parity_q;
      if ((state_q == IDLE) && load_start) begin
         parity_d = 1'b0;
      end else if (accept && ((^in_data) ^ in_par)) begin
         parity_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

endmodule

// File: tb/tb_packet_sram_loader.sv
// Directed bench for packet_sram_loader: a stream-level model predicts every
// SRAM write; a negedge monitor compares each write and counts done pulses.
module tb_packet_sram_loader;

   localparam int PACKET_W = 64;
   localparam int IN_W     = 16;
   localparam int ADDR_W   = 10;
   localparam int DEPTH    = 4;
   localparam int WPP      = PACKET_W / IN_W;

   logic                clk = 1'b0;
   logic                reset;
   logic                load_start;
   logic                in_valid;
   logic [IN_W-1:0]     in_data;
   logic                in_last;
   logic                in_ready;
   logic                sram_busy;
   logic                sram_wen;
   logic [ADDR_W-1:0]   sram_addr;
   logic [PACKET_W-1:0] sram_wdata;
   logic                load_busy;
   logic                load_done;
   logic [ADDR_W:0]     pkt_count;
   logic                overflow_err;
`ifdef PKT_LOADER_PARITY_EN
   logic                in_par;
   logic                parity_err;
`endif

   always #5 clk = ~clk;

   packet_sram_loader #(
      .PACKET_W (PACKET_W),
      .IN_W     (IN_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .load_start   (load_start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .sram_busy    (sram_busy),
      .sram_wen     (sram_wen),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .load_busy    (load_busy),
      .load_done    (load_done),
      .pkt_count    (pkt_count),
`ifdef PKT_LOADER_PARITY_EN
      .in_par       (in_par),
      .parity_err   (parity_err),
`endif
      .overflow_err (overflow_err)
   );

   typedef struct {
      logic [ADDR_W-1:0]   addr;
      logic [PACKET_W-1:0] data;
   } wr_t;

   int              total = 0;
   int              bad = 0;
   int              done_cnt = 0;
   int              wr_cnt = 0;
   wr_t             exp_q[$];
   wr_t             wr_log[$];
   logic [IN_W-1:0] stim[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: the stream is cut into WPP-word packets, last one zero-padded,
   // written to addresses 0,1,... until DEPTH packets have been stored.
   task automatic model_load(output int n_exp, output logic ovf);
      int npk;
      npk = (stim.size() + WPP - 1) / WPP;
      for (int p = 0; p < npk; p++) begin
         wr_t w;
         w.addr = ADDR_W'(p);
         w.data = '0;
         for (int k = 0; k < WPP; k++) begin
            if (p * WPP + k < stim.size()) begin
               w.data[k*IN_W +: IN_W] = stim[p*WPP + k];
            end
         end
         if (p < DEPTH) exp_q.push_back(w);
      end
      n_exp = (npk < DEPTH) ? npk : DEPTH;
      ovf   = (npk > DEPTH);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (sram_wen) begin
            wr_t a;
            wr_t e;
            a.addr = sram_addr;
            a.data = sram_wdata;
            $display("write addr=%0d data=%h", sram_addr, sram_wdata);
            chk("wen_during_busy", {63'd0, sram_busy}, 64'd0);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", {54'd0, sram_addr}, {54'd0, e.addr});
               chk("wr_data", sram_wdata, e.data);
            end
            wr_log.push_back(a);
            wr_cnt++;
         end
         if (load_done) done_cnt++;
      end
   end

   task automatic send_word(input logic [IN_W-1:0] d, input logic last, input logic badp);
      int  n;
      bit  got;
      n   = 0;
      got = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
`ifdef PKT_LOADER_PARITY_EN
      in_par   = (^d) ^ badp;
`endif
      while (!got && n < 100) begin
         @(negedge clk);
         if (in_ready) got = 1;
         else n++;
      end
      if (got) begin
         @(posedge clk);
         #1;
      end else begin
         chk("accept_timeout", 64'd0, 64'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Holds sram_busy for three cycles after WRITE is entered.
   task automatic contention_hold();
      wr_t e;
      e = exp_q[0];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("busy_wen", {63'd0, sram_wen}, 64'd0);
         chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
         chk("busy_addr", {54'd0, sram_addr}, {54'd0, e.addr});
         chk("busy_data", sram_wdata, e.data);
         @(posedge clk);
         #1;
      end
      sram_busy = 1'b0;
      @(negedge clk);
      chk("busy_release_wen", {63'd0, sram_wen}, 64'd1);
   endtask

   task automatic run_load(input string tag, input int busy_idx, input int ls_idx, input int par_idx);
      int   n_exp;
      logic ovf;
      int   bound;
      model_load(n_exp, ovf);
      done_cnt = 0;
      wr_cnt   = 0;
      wr_log.delete();
      load_start = 1'b1;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      for (int i = 0; i < stim.size(); i++) begin
         if (i == busy_idx) sram_busy = 1'b1;
         if (i == ls_idx) load_start = 1'b1;
         send_word(stim[i], (i == stim.size() - 1), (i == par_idx));
         load_start = 1'b0;
         if (i == busy_idx) contention_hold();
      end
      bound = 0;
      while (load_busy && bound < 50) begin
         @(posedge clk);
         #1;
         bound++;
      end
      chk({tag, "_end_timeout"}, {63'd0, load_busy}, 64'd0);
      chk({tag, "_writes"}, 64'(wr_cnt), 64'(n_exp));
      chk({tag, "_pkt_count"}, {53'd0, pkt_count}, 64'(n_exp));
      chk({tag, "_overflow"}, {63'd0, overflow_err}, {63'd0, ovf});
      chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      $display("load %s: words=%0d writes=%0d pkt_count=%0d overflow=%0b",
               tag, stim.size(), wr_cnt, pkt_count, overflow_err);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({tag, "_wen"}, {63'd0, sram_wen}, 64'd0);
      chk({tag, "_load_busy"}, {63'd0, load_busy}, 64'd0);
      chk({tag, "_load_done"}, {63'd0, load_done}, 64'd0);
      chk({tag, "_pkt_count"}, {53'd0, pkt_count}, 64'd0);
      chk({tag, "_overflow"}, {63'd0, overflow_err}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      sram_busy  = 1'b0;
`ifdef PKT_LOADER_PARITY_EN
      in_par     = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Base load; a stray load_start mid-stream must be ignored.
      stim.delete();
      for (int i = 1; i <= 8; i++) stim.push_back(16'(i));
      run_load("base", -1, 5, -1);
      chk("base_lit0", wr_log[0].data, 64'h0004_0003_0002_0001);
      chk("base_lit1", wr_log[1].data, 64'h0008_0007_0006_0005);
      chk("base_lit1_addr", {54'd0, wr_log[1].addr}, 64'd1);

      // Early last: zero-padded second packet.
      stim.delete();
      for (int i = 1; i <= 5; i++) stim.push_back(16'h00A0 + 16'(i));
      run_load("partial", -1, -1, -1);
      chk("partial_lit0", wr_log[0].data, 64'h00A4_00A3_00A2_00A1);
      chk("partial_lit1", wr_log[1].data, 64'h0000_0000_0000_00A5);

      // Read side owns the port for three cycles as WRITE is entered.
      stim.delete();
      for (int i = 1; i <= 4; i++) stim.push_back(16'h0B00 + 16'(i));
      run_load("contend", 3, -1, -1);
      chk("contend_lit0", wr_log[0].data, 64'h0B04_0B03_0B02_0B01);

      // Five packets into four slots.
      stim.delete();
      for (int i = 0; i < 20; i++) stim.push_back(16'h0C00 + 16'(i));
      run_load("ovf", -1, -1, -1);
      chk("ovf_lit_last_addr", {54'd0, wr_log[3].addr}, 64'd3);
      chk("ovf_lit_flag", {63'd0, overflow_err}, 64'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("ovf_sticky_flag", {63'd0, overflow_err}, 64'd1);
      chk("ovf_sticky_count", {53'd0, pkt_count}, 64'd4);

      // Reset after two words of the first packet; nothing may be written.
      load_start = 1'b1;
      @(posedge clk);
      #1;
      load_start = 1'b0;
      send_word(16'h0E01, 1'b0, 1'b0);
      send_word(16'h0E02, 1'b0, 1'b0);
      @(negedge clk);
      chk("midload_busy", {63'd0, load_busy}, 64'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_reset_outputs("midreset");
      @(posedge clk);
      #1;
      stim.delete();
      for (int i = 1; i <= 4; i++) stim.push_back(16'h0D00 + 16'(i));
      run_load("after_reset", -1, -1, -1);
      chk("after_reset_lit", wr_log[0].data, 64'h0D04_0D03_0D02_0D01);
      chk("after_reset_addr", {54'd0, wr_log[0].addr}, 64'd0);

`ifdef PKT_LOADER_PARITY_EN
      stim.delete();
      stim.push_back(16'h0003);
      run_load("parity", -1, -1, 0);
      chk("parity_err_set", {63'd0, parity_err}, 64'd1);
      chk("parity_word_stored", wr_log[0].data, 64'h0000_0000_0000_0003);
      stim.delete();
      stim.push_back(16'h0005);
      run_load("parity_clear", -1, -1, -1);
      chk("parity_err_cleared", {63'd0, parity_err}, 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
